ext_irq_ctrl: RTL and testbench

//  Machine external interrupt controller feeding int_req of the CSR register file (cause 0x8000000b).

---
 rtl/ext_irq_pkg.sv | 13 +
 rtl/irq_gateway.sv | 44 ++++
 rtl/ext_irq_ctrl.sv | 120 ++++++++++++
 tb/tb_ext_irq_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ext_irq_pkg.sv
// Register map and shared constants for the machine external interrupt controller.
package ext_irq_pkg;

    localparam logic [7:0]  REG_PENDING   = 8'h00;
    localparam logic [7:0]  REG_ENABLE    = 8'h04;
    localparam logic [7:0]  REG_THRESHOLD = 8'h08;
    localparam logic [7:0]  REG_CLAIM     = 8'h0C;
    localparam logic [7:0]  REG_PRIO_BASE = 8'h10;

    localparam int unsigned IRQ_ID_W  = 5;
    localparam logic [31:0] MEI_CAUSE = 32'h8000_000b;

endpackage

// File: rtl/irq_gateway.sv
// Per-source level gateway: latches a request until claimed, blocks re-entry until completed.
// Optional IRQ_SYNC_EN adds a 2-flop input synchronizer ahead of the gateway.
module irq_gateway (
    input  logic clock,
    input  logic reset_n,
    input  logic src,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_service
);

    logic src_q;

`ifdef IRQ_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clock) begin
        if (!reset_n) sync <= '0;
        else          sync <= {sync[0], src};
    end

    assign src_q = sync[1];
`else
    assign src_q = src;
`endif

    // pending and in_service are never both set, so claim and a new set cannot collide
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            if (claim) begin
                pending    <= 1'b0;
                in_service <= 1'b1;
            end else if (src_q && !pending && !in_service) begin
                pending <= 1'b1;
            end
            if (complete) in_service <= 1'b0;
        end
    end

endmodule

// File: rtl/ext_irq_ctrl.sv
// Machine external interrupt controller: register file, priority arbiter and registered int_req/irq_id.
// Build option IRQ_SYNC_EN (in irq_gateway) synchronizes irq_src before the gateways.
module ext_irq_ctrl
    import ext_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned PRIO_W  = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_SRC-1:0]  irq_src,
    input  logic [7:0]          reg_addr,
    input  logic [31:0]         reg_wdata,
    input  logic                reg_w_en,
    input  logic                reg_r_en,
    output logic [31:0]         reg_rdata,
    output logic                int_req,
    output logic [IRQ_ID_W-1:0] irq_id
);

    logic [NUM_SRC-1:0]  enable;
    logic [PRIO_W-1:0]   threshold;
    logic [PRIO_W-1:0]   prio [NUM_SRC];

    logic [NUM_SRC-1:0]  pend;
    logic [NUM_SRC-1:0]  in_svc;
    logic [NUM_SRC-1:0]  claim_vec;
    logic [NUM_SRC-1:0]  complete_vec;

    logic                any_elig;
    logic [IRQ_ID_W-1:0] best_id;
    logic [PRIO_W-1:0]   best_prio;

    logic [7:0]          prio_off;
    logic                prio_hit;
    logic                claim_hit;
    logic                unused_bits;

    assign prio_off    = reg_addr - REG_PRIO_BASE;
    assign prio_hit    = (reg_addr >= REG_PRIO_BASE) && (prio_off[1:0] == 2'b00);
    assign claim_hit   = (reg_addr == REG_CLAIM);
    assign unused_bits = ^{reg_wdata, in_svc};

    genvar g;
    for (g = 0; g < NUM_SRC; g++) begin : g_gw
        irq_gateway u_gw (
            .clock      (clock),
            .reset_n    (reset_n),
            .src        (irq_src[g]),
            .claim      (claim_vec[g]),
            .complete   (complete_vec[g]),
            .pending    (pend[g]),
            .in_service (in_svc[g])
        );
    end

    // Ascending scan with strict '>' gives ties to the lowest ID
    always_comb begin
        any_elig  = 1'b0;
        best_id   = '0;
        best_prio = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pend[i] && enable[i] && (prio[i] > threshold) &&
                (!any_elig || (prio[i] > best_prio))) begin
                any_elig  = 1'b1;
                best_prio = prio[i];
                best_id   = IRQ_ID_W'(i + 1);
            end
        end
    end

    always_comb begin
        claim_vec    = '0;
        complete_vec = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            claim_vec[i]    = reg_r_en && claim_hit && any_elig &&
                              (best_id == IRQ_ID_W'(i + 1));
            complete_vec[i] = reg_w_en && claim_hit &&
                              (reg_wdata[IRQ_ID_W-1:0] == IRQ_ID_W'(i + 1));
        end
    end

    always_comb begin
        reg_rdata = '0;
        if (reg_r_en) begin
            case (reg_addr)
                REG_PENDING:   reg_rdata[NUM_SRC-1:0]  = pend;
                REG_ENABLE:    reg_rdata[NUM_SRC-1:0]  = enable;
                REG_THRESHOLD: reg_rdata[PRIO_W-1:0]   = threshold;
                REG_CLAIM:     reg_rdata[IRQ_ID_W-1:0] = best_id;
                default: begin
                    for (int unsigned i = 0; i < NUM_SRC; i++) begin
                        if (prio_hit && (prio_off[7:2] == 6'(i))) reg_rdata[PRIO_W-1:0] = prio[i];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            enable    <= '0;
            threshold <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) prio[i] <= '0;
            int_req   <= 1'b0;
            irq_id    <= '0;
        end else begin
            if (reg_w_en) begin
                if (reg_addr == REG_ENABLE)    enable    <= reg_wdata[NUM_SRC-1:0];
                if (reg_addr == REG_THRESHOLD) threshold <= reg_wdata[PRIO_W-1:0];
                for (int unsigned i = 0; i < NUM_SRC; i++) begin
                    if (prio_hit && (prio_off[7:2] == 6'(i))) prio[i] <= reg_wdata[PRIO_W-1:0];
                end
            end
            int_req <= any_elig;
            irq_id  <= best_id;
        end
    end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed self-checking bench for ext_irq_ctrl (default and IRQ_SYNC_EN builds).
module tb_ext_irq_ctrl;
    import ext_irq_pkg::*;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  irq_src = '0;
    logic [7:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic        reg_w_en = 1'b0;
    logic        reg_r_en = 1'b0;
    logic [31:0] reg_rdata;
    logic        int_req;
    logic [4:0]  irq_id;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rd;

    ext_irq_ctrl #(.NUM_SRC(8), .PRIO_W(3)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .irq_src   (irq_src),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_w_en  (reg_w_en),
        .reg_r_en  (reg_r_en),
        .reg_rdata (reg_rdata),
        .int_req   (int_req),
        .irq_id    (irq_id)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reg_write(input logic [7:0] addr, input logic [31:0] data);
        reg_addr  = addr;
        reg_wdata = data;
        reg_w_en  = 1'b1;
        tick();
        reg_w_en  = 1'b0;
    endtask

    // read without crossing a clock edge: no side effect
    task automatic peek(input logic [7:0] addr, output logic [31:0] data);
        reg_addr = addr;
        reg_r_en = 1'b1;
        #1;
        data = reg_rdata;
        reg_r_en = 1'b0;
    endtask

    task automatic claim(output logic [31:0] data);
        reg_addr = REG_CLAIM;
        reg_r_en = 1'b1;
        #1;
        data = reg_rdata;
        tick();
        reg_r_en = 1'b0;
    endtask

    initial begin
        // 1: reset state
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("rst_int_req", 32'(int_req), 0);
        check("rst_irq_id", 32'(irq_id), 0);
        peek(REG_PENDING, rd);   check("rst_pending", rd, 0);
        peek(REG_ENABLE, rd);    check("rst_enable", rd, 0);
        peek(REG_THRESHOLD, rd); check("rst_threshold", rd, 0);
        peek(REG_CLAIM, rd);     check("rst_claim", rd, 0);
        for (int i = 0; i < 8; i++) begin
            peek(8'(16 + 4 * i), rd);
            check("rst_prio", rd, 0);
        end
        reg_write(REG_PENDING, 32'hFF);
        peek(REG_PENDING, rd);   check("pending_ro", rd, 0);
        reg_write(REG_ENABLE, 32'hFFFF_FFFF);
        peek(REG_ENABLE, rd);    check("enable_width", rd, 32'hFF);
        peek(8'h40, rd);         check("unmapped", rd, 0);
        reg_addr = REG_ENABLE; #1;
        check("no_r_en", reg_rdata, 0);

        // 2: single source, latency and claim
        reg_write(8'h18, 32'hFFFF_FFFB);
        peek(8'h18, rd);         check("prio2_width", rd, 3);
        reg_write(REG_ENABLE, 32'h04);
        reg_write(REG_THRESHOLD, 1);
        irq_src = 8'h04;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == 1) irq_src = 8'h00;
            if (k < LAT) check("lat_early", 32'(int_req), 0);
        end
        check("lat_int_req", 32'(int_req), 1);
        check("lat_irq_id", 32'(irq_id), 3);
        claim(rd);               check("claim_3", rd, 3);
        check("int_req_claim_edge", 32'(int_req), 1);
        tick();
        check("int_req_after_claim", 32'(int_req), 0);
        reg_write(REG_CLAIM, 3);

        // 3: tie to lowest ID, then higher priority wins
        reg_write(8'h14, 4);
        reg_write(8'h24, 4);
        reg_write(REG_ENABLE, 32'h22);
        irq_src = 8'h22;
        tick();
        irq_src = 8'h00;
        repeat (LAT) tick();
        check("tie_irq_id", 32'(irq_id), 2);
        claim(rd);               check("tie_claim", rd, 2);
        reg_write(8'h24, 6);
        claim(rd);               check("prio_claim", rd, 6);
        claim(rd);               check("empty_claim", rd, 0);
        peek(REG_PENDING, rd);   check("pending_cleared", rd, 0);
        reg_write(REG_CLAIM, 2);
        reg_write(REG_CLAIM, 6);

        // 4: held source gated by in_service until completed
        reg_write(REG_ENABLE, 32'h04);
        irq_src = 8'h04;
        repeat (LAT + 1) tick();
        check("held_int_req", 32'(int_req), 1);
        claim(rd);               check("held_claim", rd, 3);
        repeat (3) tick();
        peek(REG_PENDING, rd);   check("no_repend", rd, 0);
        check("held_int_req_low", 32'(int_req), 0);
        reg_write(REG_CLAIM, 7);
        tick();
        peek(REG_PENDING, rd);   check("complete7_ignored", rd, 0);
        reg_write(REG_THRESHOLD, 3);
        reg_write(REG_CLAIM, 3);
        peek(REG_PENDING, rd);   check("repend_not_same", rd, 0);
        tick();
        peek(REG_PENDING, rd);   check("repend_next", rd, 32'h04);

        // 5: threshold gating
        repeat (3) tick();
        check("thr_block_int_req", 32'(int_req), 0);
        check("thr_block_irq_id", 32'(irq_id), 0);
        reg_write(REG_THRESHOLD, 2);
        check("thr_write_edge", 32'(int_req), 0);
        tick();
        check("thr_open_int_req", 32'(int_req), 1);
        check("thr_open_irq_id", 32'(irq_id), 3);

        // 6: reset during service
        claim(rd);               check("svc_claim", rd, 3);
        check("svc_int_req", 32'(int_req), 1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_int_req", 32'(int_req), 0);
        check("mid_rst_irq_id", 32'(irq_id), 0);
        peek(REG_ENABLE, rd);    check("mid_rst_enable", rd, 0);
        peek(REG_THRESHOLD, rd); check("mid_rst_thr", rd, 0);
        peek(8'h18, rd);         check("mid_rst_prio2", rd, 0);
        peek(REG_PENDING, rd);   check("mid_rst_pending", rd, 0);
        reset_n = 1'b1;
        for (int k = 1; k < LAT; k++) begin
            tick();
            peek(REG_PENDING, rd);
            check("post_rst_pending", rd, (k == LAT - 1) ? 32'h04 : 32'h0);
        end
        repeat (2) tick();
        check("post_rst_int_req", 32'(int_req), 0);
        check("post_rst_irq_id", 32'(irq_id), 0);
        irq_src = 8'h00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
